// File: rtl/vram_write_buffer.sv
// vram_write_buffer
//
// Producer side of the GPU VRAM write port. CPU byte writes are accepted on
// any cycle and queued in a circular FIFO; they are replayed to VRAM one byte
// per clock, and only while video timing reports the writable window, so the
// renderers never see memory change mid-frame.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous, active-high reset
//   cpu_wr_en     CPU write request, one byte per asserted cycle
//   cpu_address   CPU write address
//   cpu_data      CPU write data
//   writable      VRAM write window from video timing
//   clr_overflow  clears the sticky overflow flag
//   vram_we       VRAM write strobe, one cycle per byte
//   vram_address  VRAM write address
//   vram_data     VRAM write data
//   full          FIFO holds DEPTH entries
//   empty         FIFO holds no entries
//   count         current occupancy
//   overflow      sticky: at least one CPU write was dropped
//   drained       empty and no write in flight

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_write_buffer #(
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0]      cpu_address,
  input  logic [7:0]                 cpu_data,
  input  logic                       writable,
  input  logic                       clr_overflow,
  output logic                       vram_we,
  output logic [ADDR_WIDTH-1:0]      vram_address,
  output logic [7:0]                 vram_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_address [DEPTH];
  logic [7:0]            mem_data    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;

  logic push;
  logic pop;

  // full/empty are the registered flags from before the edge, so a pop in the
  // same cycle never rescues a push into a full FIFO, and a push into an
  // empty FIFO is not popped until the following edge.
  assign push = cpu_wr_en && !full;
  assign pop  = writable && !empty;

  assign drained = empty && !vram_we;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: storage array has no reset; stale contents are unreachable because
  // the pointers and count are reset, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_address[wr_ptr] <= cpu_address;
      mem_data[wr_ptr]    <= cpu_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      vram_we      <= 1'b0;
      vram_address <= '0;
      vram_data    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        vram_address <= mem_address[rd_ptr];
        vram_data    <= mem_data[rd_ptr];
      end
      // Strobe lasts exactly one cycle per popped entry; address/data hold.
      vram_we <= pop;

      count <= count_next;
      full  <= (count_next == CNT_DEPTH);
      empty <= (count_next == '0);

      // A drop on the same edge as a clear leaves the flag set.
      if (cpu_wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
